// File: rtl/sm_display_scan_pkg.sv
// sm_display_scan_pkg: segment codes, conversion FSM states and BCD helpers for the display stage
package sm_display_scan_pkg;
  typedef enum logic [1:0] {CONV_IDLE, CONV_LOAD, CONV_SHIFT, CONV_DONE} conv_state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/sm_display_scan_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one shift per cycle with start/busy/done handshake
module bin2bcd_seq
  import sm_display_scan_pkg::*;
#(
  parameter int MAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [MAG_W-1:0] bin,
  output logic             busy,
  output logic             load,
  output logic             done,
  output logic [11:0]      bcd
);
  localparam int CW = $clog2(MAG_W + 1);
  conv_state_t state, state_nxt;
  logic [MAG_W-1:0] sr;
  logic [CW-1:0] cnt;
  logic [11:0] adj;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= CONV_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == CONV_IDLE  ? (start ? CONV_LOAD : CONV_IDLE) :
                state == CONV_LOAD  ? CONV_SHIFT :
                state == CONV_SHIFT ? (cnt == CW'(MAG_W - 1) ? CONV_DONE : CONV_SHIFT) :
                CONV_IDLE;
    busy = state != CONV_IDLE;
    load = state == CONV_LOAD;
    done = state == CONV_DONE;
    adj  = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  end
  // adjust-then-shift moves the next binary bit into the BCD units nibble
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sr  <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= bin;
      bcd <= '0;
      cnt <= '0;
    end else if (state == CONV_SHIFT) begin
      {bcd, sr} <= {adj[10:0], sr, 1'b0};
      cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/sm_display_scan.sv
// sm_display_scan: converts sign/magnitude to BCD and multiplexes it onto a 4-digit common-anode display
module sm_display_scan
  import sm_display_scan_pkg::*;
#(
  parameter int MAG_W          = 8,
  parameter int REFRESH_CYCLES = 100_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MAG_W-1:0] mag,
  input  logic             sign,
  output logic [0:6]       seg,
  output logic [3:0]       an
);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  logic [MAG_W:0] last;
  logic pending, start, busy, load, done;
  logic [11:0] bcd;
  logic [6:0] disp [4];
  logic [RW-1:0] rcnt;
  logic [1:0] idx;
  assign start = !busy && (pending || {sign, mag} != last);
  bin2bcd_seq #(.MAG_W(MAG_W)) u_conv (
    .clk(clk), .reset(reset), .start(start), .bin(mag),
    .busy(busy), .load(load), .done(done), .bcd(bcd)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last    <= '0;
      pending <= 1'b1;
    end else if (load) begin
      last    <= {sign, mag};
      pending <= 1'b0;
    end
  // all four slots update together so a frame never mixes two values
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 4; i++) disp[i] <= SEG_BLANK;
    end else if (done) begin
      disp[0] <= seg_digit(bcd[3:0]);
      disp[1] <= bcd[11:4] == 8'd0 ? SEG_BLANK : seg_digit(bcd[7:4]);
      disp[2] <= bcd[11:8] == 4'd0 ? SEG_BLANK : seg_digit(bcd[11:8]);
      disp[3] <= last[MAG_W] && bcd != 12'd0 ? SEG_MINUS : SEG_BLANK;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rcnt <= '0;
      idx  <= '0;
      an   <= 4'b1111;
      seg  <= SEG_BLANK;
    end else begin
      rcnt <= rcnt == RW'(REFRESH_CYCLES - 1) ? '0 : rcnt + RW'(1);
      idx  <= rcnt == RW'(REFRESH_CYCLES - 1) ? idx + 2'd1 : idx;
      an   <= ~(4'b0001 << idx);
      seg  <= disp[idx];
    end
endmodule
